// File: rtl/sevenseg_to_braille.sv
// Decodes hex digit pairs from a 7-segment stream to bytes, maps them to Braille ASCII cells, and
// queues the cells in a show-ahead FIFO. Define SEVENSEG_LOWERCASE_FOLD_EN to map 0x60-0x7F as 0x40-0x5F.
module sevenseg_to_braille #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_valid,
  output logic       seg_ready,
  input  logic [1:7] seg,
  output logic       braille_valid,
  input  logic       braille_ready,
  output logic [1:6] braille,
  output logic       err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Braille ASCII cells for 0x20..0x5F, dot 1 in the MSB.
  localparam logic [5:0] CellRom [64] = '{
    6'b000000, 6'b011101, 6'b000010, 6'b001111, 6'b110101, 6'b100101, 6'b111101, 6'b001000,
    6'b111011, 6'b011111, 6'b100001, 6'b001101, 6'b000001, 6'b001001, 6'b000101, 6'b001100,
    6'b001011, 6'b010000, 6'b011000, 6'b010010, 6'b010011, 6'b010001, 6'b011010, 6'b011011,
    6'b011001, 6'b001010, 6'b100011, 6'b000011, 6'b110001, 6'b111111, 6'b001110, 6'b100111,
    6'b000100, 6'b100000, 6'b110000, 6'b100100, 6'b100110, 6'b100010, 6'b110100, 6'b110110,
    6'b110010, 6'b010100, 6'b010110, 6'b101000, 6'b111000, 6'b101100, 6'b101110, 6'b101010,
    6'b111100, 6'b111110, 6'b111010, 6'b011100, 6'b011110, 6'b101001, 6'b111001, 6'b010111,
    6'b101101, 6'b101111, 6'b101011, 6'b010101, 6'b110011, 6'b110111, 6'b000110, 6'b000111
  };

  typedef enum logic [1:0] {StHi, StLo, StPush} state_e;

  state_e          state_q, state_d;
  logic [3:0]      hi_q, hi_d;
  logic [1:6]      cell_q, cell_d;
  logic            err_q, err_d;

  logic [1:7]      seg_in;
  logic            dig_ok;
  logic [3:0]      dig;
  logic [7:0]      chr, fold;
  logic            map_ok;
  logic [5:0]      idx;

  logic [1:6]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            full, push, pop;

  assign seg_in = SEG_ACTIVE_LOW ? ~seg : seg;

  always_comb begin
    dig_ok = 1'b1;
    dig    = 4'h0;
    case (seg_in)
      7'b1111110: dig = 4'h0;
      7'b0110000: dig = 4'h1;
      7'b1101101: dig = 4'h2;
      7'b1111001: dig = 4'h3;
      7'b0110011: dig = 4'h4;
      7'b1011011: dig = 4'h5;
      7'b1011111: dig = 4'h6;
      7'b1110000: dig = 4'h7;
      7'b1111111: dig = 4'h8;
      7'b1111011: dig = 4'h9;
      7'b1110111: dig = 4'hA;
      7'b0011111: dig = 4'hB;
      7'b1001110: dig = 4'hC;
      7'b0111101: dig = 4'hD;
      7'b1001111: dig = 4'hE;
      7'b1000111: dig = 4'hF;
      default:    dig_ok = 1'b0;
    endcase
  end

  always_comb begin
    chr  = {hi_q, dig};
    fold = chr;
`ifdef SEVENSEG_LOWERCASE_FOLD_EN
    if (chr[7:5] == 3'b011) fold = chr - 8'h20;
`else
`endif
    map_ok = (fold >= 8'h20) && (fold < 8'h60);
    idx    = fold[5:0] - 6'h20;
  end

  assign full          = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign braille_valid = (count_q != '0);
  assign pop           = braille_valid & braille_ready;
  assign braille       = braille_valid ? mem_q[rptr_q] : 6'b000000;
  assign seg_ready     = (state_q != StPush);
  assign err           = err_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cell_d  = cell_q;
    err_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      StHi: begin
        if (seg_valid) begin
          if (dig_ok) begin
            hi_d    = dig;
            state_d = StLo;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLo: begin
        if (seg_valid) begin
          if (dig_ok && map_ok) begin
            cell_d  = CellRom[idx];
            state_d = StPush;
          end else begin
            err_d   = 1'b1;
            state_d = StHi;
          end
        end
      end
      StPush: begin
        if (!full || pop) begin
          push    = 1'b1;
          state_d = StHi;
        end
      end
      default: state_d = StHi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHi;
      hi_q    <= 4'h0;
      cell_q  <= 6'b000000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cell_q  <= cell_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  // Storage needs no reset; the read mux masks it while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cell_q;
  end

endmodule
